puf_result_uart: RTL and testbench
==================================

# puf_result_uart

Readout stage downstream of the PUF randomness-test controller. Once the controller has written its per-test pass counts into the result RAM, this block reads `N_BYTES` consecutive bytes from the RAM read port and serialises them on a UART TX line (8N1, LSB first) to the host. It runs in the controller's clock domain and needs no software involvement.

## Interface
- `N_BYTES`, 8: number of result bytes sent per dump (1..255).
- `ADDR_W`, 13: RAM address width.
- `START_ADDR`, 1: RAM address of the first result byte. The controller writes test1..test8 at addresses 1..8.
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200). Minimum 2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: dump request. Rising edge triggers a dump; typically the controller's write enable inverted.
- `mem_raddr`, out, `ADDR_W`: RAM read address.
- `mem_dout`, in, 8: RAM read data, synchronous with 1-cycle latency.
- `tx`, out, 1: UART serial output. Idle high.
- `busy`, out, 1: high while a dump is in progress.
- `done`, out, 1: sticky; set when a dump completes, cleared when the next dump is accepted.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `mem_raddr`=`START_ADDR`, state IDLE, all counters 0.
- A registered copy of `start` gives rising-edge detection. Edges are only accepted in IDLE; edges while `busy`=1 are ignored and are not queued.
- States:
  - **IDLE**: on an accepted edge, set `mem_raddr`=`START_ADDR`, byte_cnt=0, `busy`=1, `done`=0, then go to READ.
  - **READ**: wait one cycle for RAM latency, then go to LOAD.
  - **LOAD**: shift_reg ← `mem_dout`, `tx`←0 (start bit), bit_cnt=0, baud_cnt=0, then go to START.
  - **START**: hold `tx` for `CLKS_PER_BIT` cycles, then go to DATA.
  - **DATA**: drive `tx`=shift_reg[0] and shift right every `CLKS_PER_BIT` cycles, 8 bits total, then go to STOP.
  - **STOP**: drive `tx`=1 for `CLKS_PER_BIT` cycles. Then:
    - if byte_cnt=`N_BYTES`-1, go to CSUM (macro on) or FIN;
    - otherwise increment `mem_raddr` and byte_cnt and go to READ.
  - **CSUM** (macro on only): load the checksum, then send it with the same start/data/stop sequence; finish to FIN.
  - **FIN**: `busy`←0, `done`←1, return to IDLE.
- `mem_raddr` is plain binary and wraps at 2^`ADDR_W`. The bench never crosses the wrap.
- baud_cnt width is clog2(`CLKS_PER_BIT`).

## Timing
- Accepted edge at clock edge k:
  - `busy`=1 after edge k;
  - `tx` falls after edge k+2;
  - first data bit starts at k+2+`CLKS_PER_BIT`.
- Each byte occupies exactly 10·`CLKS_PER_BIT` cycles of `tx`.
- Inter-byte gap: 2 cycles of idle-high (READ, LOAD) between a stop bit and the next start bit.
- Full dump length without checksum: 2 + `N_BYTES`·(10·`CLKS_PER_BIT`+2) − 2 + 1 cycles from edge k to `done` rising.
- `rst` asserted mid-frame: `tx` goes to 1 immediately (asynchronous), and the frame is truncated. Everything returns to reset values; no resume after reset release.
- `start` held high continuously triggers exactly one dump.
- `start` rising on the same cycle as FIN is ignored, because the FSM is not yet in IDLE.

## Configuration
- `PUF_RESULT_CSUM_EN` defined: after the last data byte, one extra byte equal to the XOR of all `N_BYTES` bytes is sent. It follows a 2-cycle gap, uses the same framing, and the dump length grows by 10·`CLKS_PER_BIT`+2 cycles.
- Undefined: the CSUM state and the checksum register are not synthesised, and STOP of the last byte goes directly to FIN.

## Test plan
- `CLKS_PER_BIT`=4, RAM[1..8]=0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x80, single `start` pulse:
  - decoded UART stream is 01 02 04 08 10 20 40 80;
  - `mem_raddr` steps 1→8;
  - `done`=1 exactly 8·42+1 cycles after the accepted edge.
- Same data with `PUF_RESULT_CSUM_EN` defined: a ninth byte 0xFF follows; with RAM all 0xAA the checksum is 0x00.
- Bit timing: RAM[1]=0x55, `N_BYTES`=1, `CLKS_PER_BIT`=4:
  - `tx` sequence per 4-cycle slot is 0,1,0,1,0,1,0,1,0,1;
  - start bit begins 2 cycles after the edge.
- Second `start` pulse during byte 3: stream is unchanged, exactly 8 bytes are sent, and `done` sets once.
- `rst` pulsed during the DATA state of byte 5:
  - `tx`=1 in the same cycle; `busy`=0, `done`=0;
  - a new `start` replays from byte 1 (RAM addr 1).
- `start` tied high from reset release: exactly one dump occurs, then the block stays in IDLE with `done`=1.

Source files
------------

// File: rtl/puf_result_uart.sv
// puf_result_uart: reads N_BYTES result bytes from the PUF result RAM and sends them on an 8N1 UART line.
// Optional feature macro PUF_RESULT_CSUM_EN appends an XOR checksum byte to every dump.
module puf_result_uart #(
   parameter int N_BYTES      = 8,
   parameter int ADDR_W       = 13,
   parameter int START_ADDR   = 1,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [7:0]        mem_dout,
   output logic              tx,
   output logic              busy,
   output logic              done
);
   localparam int                BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [7:0]        BYTE_LAST  = 8'(N_BYTES - 1);
   localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(START_ADDR);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_LOAD, S_START, S_DATA, S_STOP,
`ifdef PUF_RESULT_CSUM_EN
      S_CSUM,
`endif
      S_FIN
   } state_t;

   state_t            state_q, state_d;
   logic              start_q;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [7:0]        byte_cnt_q, byte_cnt_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              start_edge;
   logic              baud_tick;
   logic [7:0]        load_byte;

`ifdef PUF_RESULT_CSUM_EN
   logic [7:0] csum_q, csum_d;
   logic       csum_phase_q, csum_phase_d;

   // Once the data bytes are out, LOAD frames the accumulated checksum instead of RAM data.
   assign load_byte = csum_phase_q ? csum_q : mem_dout;
`else
   assign load_byte = mem_dout;
`endif

   assign start_edge = start & ~start_q;
   assign baud_tick  = (baud_cnt_q == BAUD_LAST);

   always_comb begin
      // NOTE: every _d starts as its _q so no path through the case can infer a latch.
      state_d    = state_q;
      raddr_d    = raddr_q;
      byte_cnt_d = byte_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      baud_cnt_d = baud_cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      done_d     = done_q;
`ifdef PUF_RESULT_CSUM_EN
      csum_d       = csum_q;
      csum_phase_d = csum_phase_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_edge) begin
               raddr_d    = ADDR_FIRST;
               byte_cnt_d = '0;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               state_d    = S_READ;
`ifdef PUF_RESULT_CSUM_EN
               csum_d       = '0;
               csum_phase_d = 1'b0;
`endif
            end
         end
         S_READ: state_d = S_LOAD;
         S_LOAD: begin
            shift_d    = load_byte;
            tx_d       = 1'b0;
            bit_cnt_d  = '0;
            baud_cnt_d = '0;
            state_d    = S_START;
`ifdef PUF_RESULT_CSUM_EN
            if (!csum_phase_q) csum_d = csum_q ^ mem_dout;
`endif
         end
         S_START: begin
            if (baud_tick) begin
               baud_cnt_d = '0;
               tx_d       = shift_q[0];
               state_d    = S_DATA;
            end else begin
               baud_cnt_d = baud_cnt_q + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               baud_cnt_d = '0;
               shift_d    = shift_q >> 1;
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  tx_d = shift_q[1];
               end
            end else begin
               baud_cnt_d = baud_cnt_q + BAUD_W'(1);
            end
         end
         S_STOP: begin
            if (baud_tick) begin
               baud_cnt_d = '0;
               if (byte_cnt_q != BYTE_LAST) begin
                  raddr_d    = raddr_q + ADDR_W'(1);
                  byte_cnt_d = byte_cnt_q + 8'd1;
                  state_d    = S_READ;
               end
`ifdef PUF_RESULT_CSUM_EN
               else if (!csum_phase_q) begin
                  state_d = S_CSUM;
               end
`endif
               else begin
                  state_d = S_FIN;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + BAUD_W'(1);
            end
         end
`ifdef PUF_RESULT_CSUM_EN
         S_CSUM: begin
            csum_phase_d = 1'b1;
            state_d      = S_LOAD;
         end
`endif
         S_FIN: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: the async reset drives the line idle-high at once, truncating any frame in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         start_q    <= 1'b0;
         raddr_q    <= ADDR_FIRST;
         byte_cnt_q <= '0;
         bit_cnt_q  <= '0;
         baud_cnt_q <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef PUF_RESULT_CSUM_EN
         csum_q       <= '0;
         csum_phase_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         start_q    <= start;
         raddr_q    <= raddr_d;
         byte_cnt_q <= byte_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         baud_cnt_q <= baud_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef PUF_RESULT_CSUM_EN
         csum_q       <= csum_d;
         csum_phase_q <= csum_phase_d;
`endif
      end
   end

   assign mem_raddr = raddr_q;
   assign tx        = tx_q;
   assign busy      = busy_q;
   assign done      = done_q;
endmodule

// File: tb/tb_puf_result_uart.sv
// tb_puf_result_uart: randomized directed bench; an independent UART receiver decodes tx and
// compares against byte lists and dump lengths derived from the RAM contents.
module tb_puf_result_uart;
   localparam int N  = 8;
   localparam int C  = 4;
   localparam int AW = 13;
   localparam int SA = 1;
`ifdef PUF_RESULT_CSUM_EN
   localparam int N_TX = N + 1;
`else
   localparam int N_TX = N;
`endif
   localparam int BYTE_CYC = 10 * C + 2;
   localparam int DUMP_CYC = N_TX * BYTE_CYC + 1;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] mem_raddr;
   logic [7:0]    mem_dout;
   logic          tx, busy, done;

   logic [7:0] ram [0:15];
   logic [7:0] exp_q [$];
   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // receiver / monitor state, each written by exactly one process
   logic [7:0] rx_q [$];
   int         rx_cyc_q [$];
   int         rx_ferr = 0;
   logic [7:0] rx_b;
   logic       rx_ok;
   int         rx_t;
   int         done_rises = 0;
   int         inc_steps  = 0;
   logic       done_prev  = 1'b0;
   logic [AW-1:0] raddr_prev = '0;

   puf_result_uart #(
      .N_BYTES(N), .ADDR_W(AW), .START_ADDR(SA), .CLKS_PER_BIT(C)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mem_raddr(mem_raddr),
      .mem_dout(mem_dout), .tx(tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      mem_dout <= ram[mem_raddr[3:0]];
   end

   always @(negedge clk) begin
      done_prev  <= done;
      raddr_prev <= mem_raddr;
      if (done === 1'b1 && done_prev === 1'b0) done_rises <= done_rises + 1;
      if (32'(mem_raddr) == 32'(raddr_prev) + 1) inc_steps <= inc_steps + 1;
   end

   // 8N1 receiver: sample the middle of every bit slot after a falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            rx_t = cyc;
            repeat (C / 2) @(negedge clk);
            rx_ok = (tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (C) @(negedge clk);
               rx_b[i] = tx;
            end
            repeat (C) @(negedge clk);
            rx_ok = rx_ok && (tx === 1'b1);
            rx_q.push_back(rx_b);
            rx_cyc_q.push_back(rx_t);
            if (!rx_ok) rx_ferr = rx_ferr + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: the dump is the RAM bytes from SA upward, plus their XOR when enabled.
   task automatic build_expected();
      logic [7:0] x;
      x = 8'h00;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         exp_q.push_back(ram[SA + i]);
         x = x ^ ram[SA + i];
      end
`ifdef PUF_RESULT_CSUM_EN
      exp_q.push_back(x);
`endif
   endtask

   task automatic randomize_ram();
      for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
   endtask

   task automatic check_stream(input string tag, input int base, input int fbase,
                               input int rbase, input int ibase, input int edge_cyc);
      check({tag, ".nbytes"}, rx_q.size() - base, N_TX);
      for (int i = 0; i < N_TX; i++)
         check($sformatf("%s.byte%0d", tag, i),
               (base + i < rx_q.size()) ? 32'(rx_q[base + i]) : 32'hDEAD, 32'(exp_q[i]));
      check({tag, ".framing"}, rx_ferr - fbase, 0);
      check({tag, ".first_start"},
            (base < rx_cyc_q.size()) ? rx_cyc_q[base] - edge_cyc : -1, 2);
      check({tag, ".done_rises"}, done_rises - rbase, 1);
      check({tag, ".raddr_steps"}, inc_steps - ibase, N - 1);
      check({tag, ".raddr_last"}, 32'(mem_raddr), SA + N - 1);
   endtask

   // One start pulse; optionally a second pulse extra_at cycles after the accepted edge.
   task automatic run_dump(input string tag, input int extra_at);
      int base, fbase, rbase, ibase, edge_cyc;
      build_expected();
      @(negedge clk);
      base = rx_q.size(); fbase = rx_ferr; rbase = done_rises; ibase = inc_steps;
      start    = 1'b1;
      edge_cyc = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      check({tag, ".busy"}, 32'(busy), 1);
      check({tag, ".done_clr"}, 32'(done), 0);
      while (done !== 1'b1 && cyc - edge_cyc < DUMP_CYC + 50) begin
         @(negedge clk);
         start = (cyc - edge_cyc == extra_at);
      end
      start = 1'b0;
      check({tag, ".done_lat"}, cyc - edge_cyc, DUMP_CYC);
      check({tag, ".busy_end"}, 32'(busy), 0);
      repeat (2) @(negedge clk);
      check_stream(tag, base, fbase, rbase, ibase, edge_cyc);
   endtask

   initial begin
      int base, fbase, rbase, ibase, edge_cyc;
      randomize_ram();
      repeat (3) @(negedge clk);
      check("reset.tx", 32'(tx), 1);
      check("reset.busy", 32'(busy), 0);
      check("reset.done", 32'(done), 0);
      check("reset.raddr", 32'(mem_raddr), SA);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle.busy", 32'(busy), 0);

      for (int i = 0; i < N; i++) ram[SA + i] = 8'(1 << i);
      run_dump("walk", 0);

      randomize_ram();
      ram[SA] = 8'h55;
      run_dump("bit55", 0);

      randomize_ram();
      run_dump("repulse", 2 + 2 * BYTE_CYC + 10);

      for (int i = 0; i < N; i++) ram[SA + i] = 8'hAA;
      run_dump("allaa", 0);

      for (int r = 0; r < 2; r++) begin
         randomize_ram();
         run_dump($sformatf("rand%0d", r), 0);
      end

      // reset in the data phase of byte 5, then a fresh dump must replay from the first byte
      randomize_ram();
      ram[SA + 4] = 8'h00;
      @(negedge clk);
      start    = 1'b1;
      edge_cyc = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      while (cyc - edge_cyc < 2 + 4 * BYTE_CYC + C + 6) @(negedge clk);
      check("rst.pre_tx", 32'(tx), 0);
      #1 rst = 1'b1;
      #1;
      check("rst.tx", 32'(tx), 1);
      check("rst.busy", 32'(busy), 0);
      check("rst.done", 32'(done), 0);
      check("rst.raddr", 32'(mem_raddr), SA);
      @(negedge clk);
      rst = 1'b0;
      repeat (12 * C) @(negedge clk);
      check("rst.no_resume", 32'(busy), 0);
      run_dump("replay", 0);

      // start held high through reset release gives exactly one dump
      randomize_ram();
      build_expected();
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      base = rx_q.size(); fbase = rx_ferr; rbase = done_rises; ibase = inc_steps;
      rst      = 1'b0;
      edge_cyc = cyc + 1;
      @(negedge clk);
      while (done !== 1'b1 && cyc - edge_cyc < DUMP_CYC + 50) @(negedge clk);
      check("tie.done_lat", cyc - edge_cyc, DUMP_CYC);
      repeat (300) @(negedge clk);
      check("tie.busy", 32'(busy), 0);
      check("tie.done", 32'(done), 1);
      check_stream("tie", base, fbase, rbase, ibase, edge_cyc);
      start = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
